pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV64 pipeline. Detects load-use hazards

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_loaduse_det.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/pipe_loaduse_det.sv
// rtl/pipe_loaduse_det.sv - combinational load-use hazard compare between ID and EX
// Ports:
//   id_rs1, id_rs2  source registers of the instruction in ID
//   id_uses_rs2     ID instruction actually reads rs2
//   ex_rd           destination register of the instruction in EX
//   ex_mem_read     EX instruction is a load
//   lu_hazard       ID must wait one cycle for the load result
module pipe_loaduse_det
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = (ex_rd == id_rs1);
    assign w_rs2_match = id_uses_rs2 && (ex_rd == id_rs2);

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign lu_hazard = ex_mem_read && (ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs2, ex_rd/ex_mem_read   load-use hazard inputs
//   ex_branch_taken         branch/jump resolved taken in EX
//   dmem_req/dmem_ready     data-memory access in progress / completing
//   pc_we, if_id_we, id_ex_we, ex_mem_we           pipeline register enables
//   if_id_flush, id_ex_flush                       bubble inserts
//   stall_cnt, flush_cnt    saturating counts of pc_we=0 / id_ex_flush=1 cycles
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_flush,
    output logic              ex_mem_we,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [2:0] PEN_INIT = 3'(BR_PENALTY - 1);

    pctl_state_t r_state;
    pctl_state_t w_state_nxt;
    logic [2:0]  r_pen_cnt;
    logic [2:0]  w_pen_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic        w_lu_hazard;
    logic        w_mem_wait;

    pipe_loaduse_det u_loaduse_det (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hazard   (w_lu_hazard)
    );

    assign w_mem_wait = dmem_req && !dmem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pen_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pen_cnt <= w_pen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pen_nxt   = r_pen_cnt;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (reset) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_state_nxt = RUN;
            w_pen_nxt   = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_wait) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_we    = 1'b0;
                        ex_mem_we   = 1'b0;
                        w_state_nxt = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        // ID holds a wrong-path instruction, so a load-use match there is moot
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (BR_PENALTY > 1) begin
                            w_state_nxt = BR_FLUSH;
                            w_pen_nxt   = PEN_INIT;
                        end
                    end else if (w_lu_hazard) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                BR_FLUSH: begin
                    if (w_mem_wait) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_we    = 1'b0;
                        ex_mem_we   = 1'b0;
                        w_state_nxt = MEM_WAIT;
                        w_pen_nxt   = '0;
                    end else begin
                        // keep squashing fetches that were already in flight
                        if_id_flush = 1'b1;
                        if (r_pen_cnt <= 3'd1) begin
                            w_state_nxt = RUN;
                            w_pen_nxt   = '0;
                        end else begin
                            w_pen_nxt   = r_pen_cnt - 3'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    // EX is frozen here; branch and load-use get re-evaluated back in RUN
                    if (dmem_ready) begin
                        w_state_nxt = RUN;
                    end else begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        id_ex_we  = 1'b0;
                        ex_mem_we = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_pen_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (id_ex_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = 5'd1;
    logic [4:0] id_rs2 = 5'd2;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_rd = 5'd3;
    logic       ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we}
    wire [5:0]  ctl_a;
    wire [5:0]  ctl_b;
    wire [15:0] stall_a;
    wire [15:0] flush_a;
    wire [1:0]  stall_b;
    wire [1:0]  flush_b;

    int checks = 0;
    int errors = 0;

    int m_busy[2];
    int m_left[2];
    int m_stall[2];
    int m_flush[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.BR_PENALTY(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(ctl_a[5]), .if_id_we(ctl_a[4]), .if_id_flush(ctl_a[3]),
        .id_ex_we(ctl_a[2]), .id_ex_flush(ctl_a[1]), .ex_mem_we(ctl_a[0]),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_hazard_ctrl #(.BR_PENALTY(3), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(ctl_b[5]), .if_id_we(ctl_b[4]), .if_id_flush(ctl_b[3]),
        .id_ex_we(ctl_b[2]), .id_ex_flush(ctl_b[1]), .ex_mem_we(ctl_b[0]),
        .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pen_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    // Expected control word from the pipeline rules for the current inputs
    function automatic logic [5:0] exp_ctl(input int i);
        logic lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        if (reset)                     return 6'b001010;
        if (m_busy[i] != 0)            return dmem_ready ? 6'b110101 : 6'b000000;
        if (dmem_req && !dmem_ready)   return 6'b000000;
        if (m_left[i] > 0)             return 6'b111101;
        if (ex_branch_taken)           return 6'b111111;
        if (lu)                        return 6'b000111;
        return 6'b110101;
    endfunction

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            logic [5:0] e;
            e = exp_ctl(i);
            if (i == 0) begin
                chk("ctl_a", 32'(ctl_a), 32'(e));
                chk("stall_a", 32'(stall_a), 32'(m_stall[0]));
                chk("flush_a", 32'(flush_a), 32'(m_flush[0]));
            end else begin
                chk("ctl_b", 32'(ctl_b), 32'(e));
                chk("stall_b", 32'(stall_b), 32'(m_stall[1]));
                chk("flush_b", 32'(flush_b), 32'(m_flush[1]));
            end
            if (reset) begin
                m_busy[i]  = 0;
                m_left[i]  = 0;
                m_stall[i] = 0;
                m_flush[i] = 0;
            end else begin
                if (!e[5] && m_stall[i] < cmax_of(i)) m_stall[i]++;
                if (e[1] && m_flush[i] < cmax_of(i))  m_flush[i]++;
                if (m_busy[i] != 0) begin
                    if (dmem_ready) m_busy[i] = 0;
                end else if (dmem_req && !dmem_ready) begin
                    m_busy[i] = 1;
                    m_left[i] = 0;
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                end else if (ex_branch_taken) begin
                    m_left[i] = pen_of(i) - 1;
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic br, input logic req, input logic rdy,
                         input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2);
        @(negedge clk);
        reset           = rst;
        ex_branch_taken = br;
        dmem_req        = req;
        dmem_ready      = rdy;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
    endtask

    initial begin
        // reset forcing
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("reset_forced", 32'(ctl_a), 32'h0A);
        idle();
        #3 chk("run_normal", 32'(ctl_a), 32'h35);
        chk("stall_zero", 32'(stall_a), 32'd0);

        // load-use on rs1
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        #3 chk("lu_stall", 32'(ctl_a), 32'h07);
        idle();
        #3 chk("lu_release", 32'(ctl_a), 32'h35);
        chk("lu_stall_cnt", 32'(stall_a), 32'd1);
        chk("lu_flush_cnt", 32'(flush_a), 32'd1);

        // x0 and rs2 gating
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        #3 chk("x0_no_stall", 32'(ctl_a[5]), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
        #3 chk("rs2_unused", 32'(ctl_a[5]), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
        #3 chk("rs2_used", 32'(ctl_a), 32'h07);
        idle();

        // taken branch, penalty 2
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("br_c0", 32'(ctl_a), 32'h3F);
        idle();
        #3 chk("br_c1", 32'(ctl_a), 32'h3D);
        idle();
        #3 chk("br_c2", 32'(ctl_a), 32'h35);
        idle();

        // memory wait with a branch held in EX
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
            #3 chk("mw_freeze", 32'(ctl_a), 32'h00);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("mw_ready", 32'(ctl_a), 32'h35);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("mw_br_after", 32'(ctl_a), 32'h3F);
        idle();
        idle();
        #3 chk("mw_stall_cnt", 32'(stall_a), 32'd5);
        chk("mw_flush_cnt", 32'(flush_a), 32'd4);

        // branch + load-use, then branch + mem-wait
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        #3 chk("br_lu", 32'(ctl_a), 32'h3F);
        idle(); idle(); idle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("br_mw_freeze", 32'(ctl_a), 32'h00);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("br_mw_ready", 32'(ctl_a), 32'h35);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("br_mw_flush", 32'(ctl_a), 32'h3F);
        idle(); idle(); idle();
        #3 chk("s5_stall_cnt", 32'(stall_a), 32'd6);
        chk("s5_flush_cnt", 32'(flush_a), 32'd6);

        // reset inside MEM_WAIT
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("rst_mw_forced", 32'(ctl_a), 32'h0A);
        idle();
        #3 chk("rst_mw_run", 32'(ctl_a), 32'h35);
        chk("rst_stall_clr", 32'(stall_a), 32'd0);
        chk("rst_flush_clr", 32'(flush_a), 32'd0);

        // reset inside BR_FLUSH
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0);
        #3 chk("rst_br_forced", 32'(ctl_a), 32'h0A);
        idle();
        #3 chk("rst_br_run", 32'(ctl_a), 32'h35);
        chk("rst_br_run_b", 32'(ctl_b), 32'h35);

        // saturation of the 2-bit counters
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        idle();
        #3 chk("sat_stall_b", 32'(stall_b), 32'd3);
        chk("sat_flush_b", 32'(flush_b), 32'd3);
        chk("sat_stall_a", 32'(stall_a), 32'd5);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(99) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(2) == 0),
                  1'($urandom_range(1)),
                  1'($urandom_range(1)),
                  5'($urandom_range(3)),
                  5'($urandom_range(3)),
                  5'($urandom_range(3)),
                  1'($urandom_range(1)));
        end
        idle();
        idle();
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
